ula_multiciclo: RTL

Parametrised multi-cycle successor to the single-cycle combinational ALU in the CPU datapath. Accepts one operation at a time over a valid/ready handshake and computes it at `WIDTH`-bit operand precision. Add and subtract complete in one cycle; multiply (and optional divide) run iteratively, one bit per cycle. The result is held with status flags until the consumer accepts it. The block sits between the decode/register-read stage and write-back, and lets the control FSM stall on long operations.

---
 rtl/ula_pkg.sv | 27 ++
 rtl/ula_iter.sv | 108 ++++++++++
 rtl/ula_multiciclo.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared opcodes, FSM encoding and opcode classification for ula_multiciclo.
// ULA_DIV_EN enables opcode 110 (DIV) as an iterative operation.
package ula_pkg;

    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SUBI = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_DIV  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Opcodes that go through the multi-cycle datapath
    function automatic logic is_iter_op(input logic [2:0] op);
`ifdef ULA_DIV_EN
        return (op == OP_MUL) || (op == OP_DIV);
`else
        return op == OP_MUL;
`endif
    endfunction

endpackage

// File: rtl/ula_iter.sv
// Iterative datapath: shift-add multiply, plus restoring divide when ULA_DIV_EN is defined.
// One bit per cycle over WIDTH cycles; done and results are combinational on the last step.
module ula_iter
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
`ifdef ULA_DIV_EN
    input  logic               is_div,
`endif
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
`ifdef ULA_DIV_EN
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
`endif
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [RW-1:0] r_acc;
    logic [RW-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [RW-1:0] w_acc_nxt;
    logic          w_mul_run;

    assign done      = r_busy && (r_cnt == LAST);
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : RW'(0));
    assign product   = w_acc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
        end else if (r_busy) begin
            r_busy <= !done;
            r_cnt  <= done ? '0 : r_cnt + CW'(1);
        end
    end

`ifdef ULA_DIV_EN
    logic             r_div;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;

    assign w_mul_run = r_busy && !r_div;

    // Restoring step: shift next dividend bit in, keep the difference if it did not go negative
    assign w_shift   = {r_rem, r_quot[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_dvs};
    assign w_fits    = ~w_trial[WIDTH];
    assign remainder = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign quotient  = {r_quot[WIDTH-2:0], w_fits};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= 1'b0;
            r_rem  <= '0;
            r_quot <= '0;
            r_dvs  <= '0;
        end else if (start) begin
            r_div  <= is_div;
            r_rem  <= '0;
            r_quot <= a;
            r_dvs  <= b;
        end else if (r_busy && r_div) begin
            r_rem  <= remainder;
            r_quot <= quotient;
        end
    end
`else
    assign w_mul_run = r_busy;
`endif

    // Multiplier examined LSB first while the multiplicand shifts left
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (start) begin
            r_acc    <= '0;
            r_mcand  <= RW'(a);
            r_mplier <= b;
        end else if (w_mul_run) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

endmodule

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU with valid/ready handshakes: ADD/SUB in one cycle, MUL (and DIV with
// ULA_DIV_EN defined) iteratively; result and flags held until the consumer accepts.
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         opcode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               flag_z,
    output logic               flag_n,
    output logic               flag_c,
    output logic               flag_err
);

    localparam int unsigned RW = 2 * WIDTH;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_start;
    logic          w_load_single;
    logic          w_iter_done;
    logic [RW-1:0] w_sum;
    logic [RW-1:0] w_diff;
    logic [RW-1:0] w_single_res;
    logic          w_single_c;
    logic          w_single_err;
    logic [RW-1:0] w_prod;
    logic [RW-1:0] w_iter_res;
    logic          w_iter_err;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start       = 1'b0;
        w_load_single = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_iter_op(opcode)) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_CALC;
                    end else begin
                        w_load_single = 1'b1;
                        w_state_nxt   = ST_DONE;
                    end
                end
            end
            ST_CALC: if (w_iter_done) w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready)   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_sum  = RW'(A) + RW'(B);
    assign w_diff = RW'(A) - RW'(B);

    // Single-cycle operations; anything else reaching this path is illegal
    always_comb begin
        w_single_res = '0;
        w_single_c   = 1'b0;
        w_single_err = 1'b0;
        case (opcode)
            OP_ADD, OP_ADDI: begin
                w_single_res = w_sum;
                w_single_c   = w_sum[WIDTH];
            end
            OP_SUB, OP_SUBI: begin
                w_single_res = w_diff;
                w_single_c   = (A < B);
            end
            default: w_single_err = 1'b1;
        endcase
    end

`ifdef ULA_DIV_EN
    logic             r_is_div;
    logic             r_div_zero;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_div   <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (w_start) begin
            r_is_div   <= (opcode == OP_DIV);
            r_div_zero <= (B == '0);
        end
    end

    assign w_iter_res = r_is_div ? {w_rem, w_quot} : w_prod;
    assign w_iter_err = r_is_div && r_div_zero;

    ula_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_start),
        .is_div    (opcode == OP_DIV),
        .a         (A),
        .b         (B),
        .done      (w_iter_done),
        .quotient  (w_quot),
        .remainder (w_rem),
        .product   (w_prod)
    );
`else
    assign w_iter_res = w_prod;
    assign w_iter_err = 1'b0;

    ula_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_start),
        .a       (A),
        .b       (B),
        .done    (w_iter_done),
        .product (w_prod)
    );
`endif

    // Result and flags load once per operation and hold until the next load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
            flag_c   <= 1'b0;
            flag_err <= 1'b0;
        end else if (w_load_single) begin
            result   <= w_single_res;
            flag_z   <= (w_single_res == '0);
            flag_n   <= w_single_res[RW-1];
            flag_c   <= w_single_c;
            flag_err <= w_single_err;
        end else if (r_state == ST_CALC && w_iter_done) begin
            result   <= w_iter_res;
            flag_z   <= (w_iter_res == '0);
            flag_n   <= w_iter_res[RW-1];
            flag_c   <= 1'b0;
            flag_err <= w_iter_err;
        end
    end

endmodule
